// File: rtl/deframe.sv
// deframe -- byte-stream frame extractor.
//
// Hunts for a SYNC byte, collects WIDTH/8 payload bytes little-endian into an
// assembly register, then checks one trailing checksum byte (payload bytes plus
// checksum must sum to 0 mod 256).  A good frame loads a one-deep output
// register; a bad checksum, an idle timeout or an upstream error aborts the
// frame with a one-cycle out_err pulse.
//
// Handshakes: both sides use valid/ready.  A transfer happens in exactly the
// cycles where valid (in_stb / out_stb) and ready (in_rdy / out_rdy) are both
// high.  Once raised, out_stb holds, with out_dat stable, until it is taken.
//
// Ports:
//   clk      clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   in_stb   upstream byte valid
//   in_dat   upstream byte
//   in_rdy   byte accept
//   in_err   upstream framing error (level), honoured only inside a frame
//   out_stb  assembled word valid
//   out_dat  assembled word
//   out_rdy  downstream accept
//   out_err  one-cycle frame error pulse
module deframe #(
   parameter int         WIDTH   = 32,
   parameter logic [7:0] SYNC    = 8'hA5,
   parameter int         TIMEOUT = 12000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_stb,
   input  logic [7:0]       in_dat,
   output logic             in_rdy,
   input  logic             in_err,
   output logic             out_stb,
   output logic [WIDTH-1:0] out_dat,
   input  logic             out_rdy,
   output logic             out_err
);

   localparam int NB = WIDTH / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int IW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] HUNT  = 2'd0;
   localparam logic [1:0] DATA  = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;

   // FSM state; kept as a plain named signal so checkers can bind to it.
   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [CW-1:0]    cnt;
   logic [7:0]       sum;
   logic [WIDTH-1:0] asm_q;
   logic [IW-1:0]    idle;

   logic       in_frame;
   logic       abort;
   logic       acc;
   logic [7:0] sum_nx;
   logic       chk_ok;
   logic       load;
   logic       idle_run;
   logic       tmo;
   logic       err_ev;

   assign in_frame = (state != HUNT);

   // In CHECK the checksum byte may only be taken when the output register
   // can receive the word (empty, or being drained this same cycle).
   assign in_rdy = (state != CHECK) | ~out_stb | out_rdy;

   // An upstream error inside a frame wins over any byte offered that cycle.
   assign abort = in_frame & in_err;
   assign acc   = in_stb & in_rdy & ~abort;

   assign sum_nx = sum + in_dat;
   assign chk_ok = (sum_nx == 8'h00);
   assign load   = (state == CHECK) & acc & chk_ok;

   // The idle counter only advances while we are inside a frame and willing
   // to take a byte; a stall caused by a full output register is not idle.
   assign idle_run = in_frame & in_rdy & ~acc & ~abort;
   assign tmo      = idle_run & (idle == IW'(TIMEOUT - 1));

   assign err_ev = abort | tmo | ((state == CHECK) & acc & ~chk_ok);

   always_comb begin
      state_nx = state;
      case (state)
         HUNT: begin
            if (acc && (in_dat == SYNC)) state_nx = DATA;
         end
         DATA: begin
            if (abort || tmo)                        state_nx = HUNT;
            else if (acc && (cnt == CW'(NB - 1)))    state_nx = CHECK;
         end
         CHECK: begin
            if (abort || tmo || acc) state_nx = HUNT;
         end
         default: state_nx = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= HUNT;
         cnt     <= '0;
         sum     <= '0;
         asm_q   <= '0;
         idle    <= '0;
         out_stb <= 1'b0;
         out_dat <= '0;
         out_err <= 1'b0;
      end else begin
         state   <= state_nx;
         out_err <= err_ev;

         // One-deep output register: a load in the same cycle as a drain
         // keeps out_stb high with the new word.
         out_stb <= load | (out_stb & ~out_rdy);
         if (load) out_dat <= asm_q;

         // Byte count and sum are cleared while hunting, so entering DATA
         // always starts from zero.
         if (state == HUNT) begin
            cnt <= '0;
            sum <= '0;
         end else if ((state == DATA) && acc) begin
            cnt <= cnt + CW'(1);
            sum <= sum_nx;
            for (int j = 0; j < NB; j++) begin
               if (cnt == CW'(j)) asm_q[8*j +: 8] <= in_dat;
            end
         end

         if (!in_frame || acc)  idle <= '0;
         else if (idle_run)     idle <= idle + IW'(1);
      end
   end

endmodule

// File: tb/tb_deframe.sv
module tb_deframe;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_stb;
   logic [7:0]       in_dat;
   logic             in_rdy;
   logic             in_err;
   logic             out_stb;
   logic [WIDTH-1:0] out_dat;
   logic             out_rdy;
   logic             out_err;

   int   tests    = 0;
   int   fails    = 0;
   int   err_seen = 0;
   int   err_exp  = 0;
   logic prev_err = 1'b0;

   logic [WIDTH-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   deframe #(
      .WIDTH   (WIDTH),
      .SYNC    (8'hA5),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in_stb  (in_stb),
      .in_dat  (in_dat),
      .in_rdy  (in_rdy),
      .in_err  (in_err),
      .out_stb (out_stb),
      .out_dat (out_dat),
      .out_rdy (out_rdy),
      .out_err (out_err)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard side: every transfer on the output is compared with the
   // oldest expected word; error pulses are counted and must be one cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_stb && out_rdy) begin
            if (exp_q.size() == 0) check("unexpected_word", 64'(exp_q.size()), 64'd1);
            else                   check("word", 64'(out_dat), 64'(exp_q.pop_front()));
         end
         if (out_err) begin
            err_seen++;
            check("err_single", 64'(prev_err), 64'd0);
         end
      end
      prev_err = out_err;
   end

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b);
      int   n    = 0;
      logic took = 1'b0;
      in_stb = 1'b1;
      in_dat = b;
      while (!took && n < 100) begin
         @(negedge clk);
         took = in_rdy;
         @(posedge clk);
         #1;
         n++;
      end
      in_stb = 1'b0;
      check("byte_accept", 64'(took), 64'd1);
   endtask

   function automatic logic [7:0] csum(input logic [31:0] w);
      logic [7:0] s;
      s = w[7:0] + w[15:8] + w[23:16] + w[31:24];
      return 8'h00 - s;
   endfunction

   task automatic send_frame(input logic [31:0] w, input logic bad);
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
      send_byte(csum(w) + {7'd0, bad});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]  t1[6];
      logic [7:0]  t2[9];
      logic [31:0] w1, w2, w3, w4, w5;

      t1 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
      t2 = '{8'h00, 8'hFF, 8'h37, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};

      rst = 1'b1; in_stb = 1'b0; in_dat = 8'h00; in_err = 1'b0; out_rdy = 1'b1;
      cycles(3);
      check("rst_out_stb", 64'(out_stb), 64'd0);
      check("rst_out_dat", 64'(out_dat), 64'd0);
      check("rst_out_err", 64'(out_err), 64'd0);
      check("rst_state",   64'(dut.state), 64'd0);
      rst = 1'b0;
      #1;
      check("rst_in_rdy",  64'(in_rdy), 64'd1);

      // Basic frame and one-cycle latency.
      exp_q.push_back(32'h04030201);
      for (int i = 0; i < 6; i++) send_byte(t1[i]);
      check("lat_stb", 64'(out_stb), 64'd1);
      check("lat_dat", 64'(out_dat), 64'h04030201);
      check("lat_err", 64'(out_err), 64'd0);
      cycles(2);

      // Leading garbage ignored.
      exp_q.push_back(32'h44332211);
      for (int i = 0; i < 9; i++) send_byte(t2[i]);
      cycles(2);

      // Bad checksum.
      err_exp++;
      send_frame(32'h04030201, 1'b1);
      check("bad_err", 64'(out_err), 64'd1);
      check("bad_stb", 64'(out_stb), 64'd0);
      for (int k = 0; k < 3; k++) begin
         w1 = $urandom;
         exp_q.push_back(w1);
         send_frame(w1, 1'b0);
      end
      cycles(2);

      // Idle timeout inside a frame.
      send_byte(8'hA5);
      send_byte(8'h01);
      cycles(TIMEOUT - 1);
      check("tmo_early_err",   64'(out_err), 64'd0);
      check("tmo_early_state", 64'(dut.state), 64'd1);
      cycles(1);
      err_exp++;
      check("tmo_err",   64'(out_err), 64'd1);
      check("tmo_state", 64'(dut.state), 64'd0);
      exp_q.push_back(32'h04030201);
      send_frame(32'h04030201, 1'b0);
      cycles(2);

      // Backpressure: second checksum waits until the first word drains.
      out_rdy = 1'b0;
      w1 = $urandom;
      w2 = $urandom;
      exp_q.push_back(w1);
      exp_q.push_back(w2);
      send_frame(w1, 1'b0);
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) send_byte(w2[8*i +: 8]);
      in_stb = 1'b1;
      in_dat = csum(w2);
      cycles(TIMEOUT + 4);
      check("bp_in_rdy", 64'(in_rdy), 64'd0);
      check("bp_stb",    64'(out_stb), 64'd1);
      check("bp_dat",    64'(out_dat), 64'(w1));
      check("bp_state",  64'(dut.state), 64'd2);
      check("bp_no_err", 64'(err_seen), 64'(err_exp));
      out_rdy = 1'b1;
      cycles(1);
      in_stb = 1'b0;
      check("bp_cont_stb", 64'(out_stb), 64'd1);
      check("bp_new_dat",  64'(out_dat), 64'(w2));
      cycles(2);

      // Upstream error mid-frame while a word is pending.
      out_rdy = 1'b0;
      w3 = $urandom;
      exp_q.push_back(w3);
      send_frame(w3, 1'b0);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h02);
      in_err = 1'b1;
      in_stb = 1'b1;
      in_dat = 8'h03;
      cycles(1);
      in_err = 1'b0;
      in_stb = 1'b0;
      err_exp++;
      check("abort_err",   64'(out_err), 64'd1);
      check("abort_state", 64'(dut.state), 64'd0);
      check("abort_stb",   64'(out_stb), 64'd1);
      check("abort_dat",   64'(out_dat), 64'(w3));
      out_rdy = 1'b1;
      cycles(2);

      // in_err is ignored while hunting.
      w4 = $urandom;
      exp_q.push_back(w4);
      in_err = 1'b1;
      send_byte(8'hA5);
      in_err = 1'b0;
      check("hunt_err_ignored", 64'(dut.state), 64'd1);
      for (int i = 0; i < 4; i++) send_byte(w4[8*i +: 8]);
      send_byte(csum(w4));
      cycles(2);

      // Reset mid-frame with a pending word: both are discarded silently.
      out_rdy = 1'b0;
      w5 = $urandom;
      send_frame(w5, 1'b0);
      send_byte(8'hA5);
      send_byte(8'h01);
      rst = 1'b1;
      cycles(1);
      check("mrst_stb",   64'(out_stb), 64'd0);
      check("mrst_dat",   64'(out_dat), 64'd0);
      check("mrst_err",   64'(out_err), 64'd0);
      check("mrst_state", 64'(dut.state), 64'd0);
      rst = 1'b0;
      #1;
      check("mrst_in_rdy", 64'(in_rdy), 64'd1);
      cycles(TIMEOUT + 4);
      out_rdy = 1'b1;
      w1 = $urandom;
      exp_q.push_back(w1);
      send_frame(w1, 1'b0);
      cycles(5);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("err_count",   64'(err_seen), 64'(err_exp));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
